sram_rw_port_ctrl: RTL and testbench

Initiator side of the single-port SRAM macro interface (en / wmode / addr / wdata / rdata, 1-cycle registered read). It converts a valid/ready request channel into SRAM port cycles. Read data is returned through a valid/ready response channel backed by a small response FIFO. After reset it optionally zero-fills the array before accepting requests. It sits between a pipeline client (e.g. a small metadata table) and the generated SRAM macro.

---
 rtl/sram_rw_port_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl
//   Initiator side of a single-port SRAM macro with a 1-cycle registered read.
//   Requests arrive on a valid/ready channel and become SRAM port cycles. Read
//   data comes back in order through a small response FIFO on a valid/ready
//   channel. After reset the block can zero-fill the whole array before it
//   accepts requests.
//
// Ports
//   clock, reset_n            sole clock (also the macro clock), async active-low reset
//   req_valid/req_ready       request handshake (fire = valid && ready)
//   req_write/addr/wdata      request fields, ignored unless req_valid
//   resp_valid/ready/rdata    in-order read responses
//   init_done                 high once the block has reached RUN
//   sram_en/wmode/addr/wdata  drive to the macro
//   sram_rdata                from the macro, valid the cycle after a read enable
module sram_rw_port_ctrl #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 66,
  parameter int RESP_DEPTH = 2,
  parameter int INIT_ZERO  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  // One extra bit so count + in-flight read never wraps.
  localparam int CNT_W = $clog2(RESP_DEPTH + 1) + 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] initCnt_q, initCnt_d;
  logic              initDone_q, initDone_d;
  logic              rdInflight_q, rdInflight_d;

  logic [DATA_W-1:0] fifoMem_q [RESP_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]  fifoCount_q;

  logic              fire;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  occ;
  logic              creditOk;

  // Handshake terms. The credit check counts the read still in the macro so
  // that every accepted read already owns a FIFO slot; a pop in the same
  // cycle frees one, which is why req_ready looks at resp_ready.
  always_comb begin
    resp_valid = (fifoCount_q != '0);
    resp_rdata = fifoMem_q[rdPtr_q];
    pop        = resp_valid && resp_ready;
    push       = rdInflight_q;
    occ        = fifoCount_q + CNT_W'(rdInflight_q);
    creditOk   = (occ - CNT_W'(pop)) < CNT_W'(RESP_DEPTH);
    // Gating on reset_n keeps req_ready low while reset is held, including
    // the no-sweep build where the state register already reads RUN.
    req_ready  = reset_n && (state_q == ST_RUN) && creditOk;
    fire       = req_valid && req_ready;
    init_done  = initDone_q;
  end

  // Next-state and SRAM drive. INIT writes zero to one address per cycle;
  // RUN passes the request straight through, enabling only on fire.
  always_comb begin
    state_d      = state_q;
    initCnt_d    = initCnt_q;
    initDone_d   = initDone_q;
    rdInflight_d = fire && !req_write;
    sram_en      = 1'b0;
    sram_wmode   = 1'b0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (reset_n) begin
      case (state_q)
        ST_INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = initCnt_q;
          sram_wdata = '0;
          initCnt_d  = initCnt_q + 1'b1;
          if (initCnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d    = ST_RUN;
            initDone_d = 1'b1;
          end
        end
        ST_RUN: begin
          sram_en    = fire;
          sram_wmode = req_write;
          sram_addr  = req_addr;
          sram_wdata = req_wdata;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Control registers. Reset discards any read still in the macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if (INIT_ZERO != 0) begin
        state_q    <= ST_INIT;
        initDone_q <= 1'b0;
      end else begin
        state_q    <= ST_RUN;
        initDone_q <= 1'b1;
      end
      initCnt_q    <= '0;
      rdInflight_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      initCnt_q    <= initCnt_d;
      initDone_q   <= initDone_d;
      rdInflight_q <= rdInflight_d;
    end
  end

  // Response FIFO. The macro data is captured on the edge that closes the
  // in-flight cycle. Storage is cleared on reset so resp_rdata reads zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= sram_rdata;
        wrPtr_q <= (wrPtr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= (rdPtr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifoCount_q <= fifoCount_q + 1'b1;
        2'b01:   fifoCount_q <= fifoCount_q - 1'b1;
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

  // The credit rule makes overflow impossible; catch it if that ever breaks.
  noOverflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (fifoCount_q == CNT_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// tb_sram_rw_port_ctrl
//   Directed bench for sram_rw_port_ctrl. One instance runs with the zero-fill
//   sweep and talks to a behavioural SRAM macro; a second instance is built
//   without the sweep and only its idle/ready behaviour is looked at.
module tb_sram_rw_port_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 66;

  logic clock = 1'b0;
  logic reset_n;

  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  logic              req_valid2, req_ready2, req_write2;
  logic [ADDR_W-1:0] req_addr2;
  logic [DATA_W-1:0] req_wdata2;
  logic              resp_valid2, resp_ready2;
  logic [DATA_W-1:0] resp_rdata2;
  logic              init_done2;
  logic              sram_en2, sram_wmode2;
  logic [ADDR_W-1:0] sram_addr2;
  logic [DATA_W-1:0] sram_wdata2, sram_rdata2;

  int totalChecks = 0;
  int badChecks   = 0;

  localparam logic [DATA_W-1:0] DEAD = 66'h3_DEAD_BEEF_0123_4567;

  // 10-time-unit clock; inputs change on the falling edge.
  always #5 clock = ~clock;

  sram_rw_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_DEPTH(2), .INIT_ZERO(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_rw_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_DEPTH(2), .INIT_ZERO(0)) dutNoInit (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_rdata(resp_rdata2),
    .init_done(init_done2),
    .sram_en(sram_en2), .sram_wmode(sram_wmode2), .sram_addr(sram_addr2),
    .sram_wdata(sram_wdata2), .sram_rdata(sram_rdata2)
  );

  // Behavioural SRAM macro: preloaded with non-zero junk on the first edge so
  // the zero-fill sweep is visible, registered read data one cycle later.
  logic [DATA_W-1:0] sramMem [4];
  logic              modelLoaded = 1'b0;
  always @(posedge clock) begin
    if (!modelLoaded) begin
      for (int i = 0; i < 4; i++) sramMem[i] <= 66'h2_A5A5_A5A5_0000_0000 + DATA_W'(i);
      modelLoaded <= 1'b1;
    end else if (sram_en) begin
      if (sram_wmode) sramMem[sram_addr] <= sram_wdata;
      else            sram_rdata <= sramMem[sram_addr];
    end
  end

  // The second instance is never given requests.
  initial begin
    req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = 2'd1;
    req_wdata2 = '1; resp_ready2 = 1'b0; sram_rdata2 = '0;
  end

  function automatic logic [DATA_W-1:0] patVal(input int i);
    case (i)
      0:       return 66'h1_0000_1111_2222_3333;
      1:       return 66'h2_4444_5555_6666_7777;
      2:       return 66'h3_8888_9999_AAAA_BBBB;
      default: return 66'h0_CCCC_DDDD_EEEE_FFFF;
    endcase
  endfunction

  // Everything held in reset: all outputs quiet, no-sweep build shows init_done.
  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd3;
    req_wdata = '1; resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    totalChecks++; if (init_done !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_init_done got=%b want=0", init_done); end
    totalChecks++; if (req_ready !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_req_ready got=%b want=0", req_ready); end
    totalChecks++; if (resp_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_resp_valid got=%b want=0", resp_valid); end
    totalChecks++; if (sram_en !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_sram_en got=%b want=0", sram_en); end
    totalChecks++; if (sram_wmode !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_sram_wmode got=%b want=0", sram_wmode); end
    totalChecks++; if (sram_addr !== 2'd0) begin badChecks++; $display("[TB] FAIL reset_sram_addr got=%0d want=0", sram_addr); end
    totalChecks++; if (sram_wdata !== 66'd0) begin badChecks++; $display("[TB] FAIL reset_sram_wdata got=%h want=0", sram_wdata); end
    totalChecks++; if (resp_rdata !== 66'd0) begin badChecks++; $display("[TB] FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
    totalChecks++; if (init_done2 !== 1'b1) begin badChecks++; $display("[TB] FAIL reset_noinit_done got=%b want=1", init_done2); end
    totalChecks++; if (req_ready2 !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_noinit_ready got=%b want=0", req_ready2); end
    totalChecks++; if (sram_addr2 !== 2'd0) begin badChecks++; $display("[TB] FAIL reset_noinit_addr got=%0d want=0", sram_addr2); end
    req_addr = 2'd0; req_wdata = '0;
  endtask

  // Release reset: four zero-write sweep cycles, RUN on the fifth, then all
  // four addresses read back as zero.
  task automatic test_init_sweep;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      totalChecks++; if (sram_en !== 1'b1) begin badChecks++; $display("[TB] FAIL sweep_en[%0d] got=%b want=1", c, sram_en); end
      totalChecks++; if (sram_wmode !== 1'b1) begin badChecks++; $display("[TB] FAIL sweep_wmode[%0d] got=%b want=1", c, sram_wmode); end
      totalChecks++; if (sram_addr !== 2'(c)) begin badChecks++; $display("[TB] FAIL sweep_addr[%0d] got=%0d want=%0d", c, sram_addr, c); end
      totalChecks++; if (sram_wdata !== 66'd0) begin badChecks++; $display("[TB] FAIL sweep_wdata[%0d] got=%h want=0", c, sram_wdata); end
      totalChecks++; if (req_ready !== 1'b0) begin badChecks++; $display("[TB] FAIL sweep_ready[%0d] got=%b want=0", c, req_ready); end
      totalChecks++; if (init_done !== 1'b0) begin badChecks++; $display("[TB] FAIL sweep_done[%0d] got=%b want=0", c, init_done); end
    end
    @(negedge clock); #1;
    totalChecks++; if (init_done !== 1'b1) begin badChecks++; $display("[TB] FAIL run_init_done got=%b want=1", init_done); end
    totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL run_req_ready got=%b want=1", req_ready); end
    totalChecks++; if (sram_en !== 1'b0) begin badChecks++; $display("[TB] FAIL run_idle_en got=%b want=0", sram_en); end
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      req_valid = (c < 4); req_write = 1'b0; req_addr = 2'(c);
      #1;
      if (c < 4) begin
        totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL zero_rd_ready[%0d] got=%b want=1", c, req_ready); end
      end
      totalChecks++; if (resp_valid !== (c >= 2)) begin badChecks++; $display("[TB] FAIL zero_rd_valid[%0d] got=%b want=%b", c, resp_valid, c >= 2); end
      if (c >= 2) begin
        totalChecks++; if (resp_rdata !== 66'd0) begin badChecks++; $display("[TB] FAIL zero_rd_data[%0d] got=%h want=0", c, resp_rdata); end
      end
    end
    req_valid = 1'b0;
  endtask

  // Write then read the same address on the next cycle; response two cycles later.
  task automatic test_write_then_read;
    resp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = DEAD;
    #1;
    totalChecks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b1) begin badChecks++; $display("[TB] FAIL wr_en_wmode got=%b%b want=11", sram_en, sram_wmode); end
    totalChecks++; if (sram_wdata !== DEAD) begin badChecks++; $display("[TB] FAIL wr_wdata got=%h want=%h", sram_wdata, DEAD); end
    @(negedge clock);
    req_write = 1'b0; req_wdata = '0;
    #1;
    totalChecks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b0) begin badChecks++; $display("[TB] FAIL rd_en_wmode got=%b%b want=10", sram_en, sram_wmode); end
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    totalChecks++; if (resp_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL wr_rd_early_valid got=%b want=0", resp_valid); end
    @(negedge clock); #1;
    totalChecks++; if (resp_valid !== 1'b1) begin badChecks++; $display("[TB] FAIL wr_rd_valid got=%b want=1", resp_valid); end
    totalChecks++; if (resp_rdata !== DEAD) begin badChecks++; $display("[TB] FAIL wr_rd_data got=%h want=%h", resp_rdata, DEAD); end
    @(negedge clock); #1;
    totalChecks++; if (resp_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL wr_rd_drained got=%b want=0", resp_valid); end
  endtask

  // Fill with distinct patterns, then four reads back-to-back with resp_ready high.
  task automatic test_back_to_back;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 2'(c); req_wdata = patVal(c);
      #1;
      totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL b2b_wr_ready[%0d] got=%b want=1", c, req_ready); end
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      req_valid = (c < 4); req_write = 1'b0; req_addr = 2'(c); req_wdata = '0;
      #1;
      if (c < 4) begin
        totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL b2b_rd_ready[%0d] got=%b want=1", c, req_ready); end
      end
      totalChecks++; if (resp_valid !== (c >= 2 && c < 6)) begin badChecks++; $display("[TB] FAIL b2b_valid[%0d] got=%b want=%b", c, resp_valid, (c >= 2 && c < 6)); end
      if (c >= 2 && c < 6) begin
        totalChecks++; if (resp_rdata !== patVal(c - 2)) begin badChecks++; $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", c, resp_rdata, patVal(c - 2)); end
      end
    end
    req_valid = 1'b0;
  endtask

  // resp_ready low: two reads accepted, then stall; release drains in order
  // and ready comes back in the cycle of the first pop.
  task automatic test_backpressure;
    resp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
    #1;
    totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL bp_ready0 got=%b want=1", req_ready); end
    @(negedge clock);
    req_addr = 2'd3;
    #1;
    totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL bp_ready1 got=%b want=1", req_ready); end
    @(negedge clock);
    req_addr = 2'd0;
    #1;
    totalChecks++; if (req_ready !== 1'b0) begin badChecks++; $display("[TB] FAIL bp_ready2 got=%b want=0", req_ready); end
    totalChecks++; if (sram_en !== 1'b0) begin badChecks++; $display("[TB] FAIL bp_stall_en got=%b want=0", sram_en); end
    @(negedge clock); #1;
    totalChecks++; if (req_ready !== 1'b0) begin badChecks++; $display("[TB] FAIL bp_ready3 got=%b want=0", req_ready); end
    totalChecks++; if (resp_valid !== 1'b1 || resp_rdata !== patVal(1)) begin badChecks++; $display("[TB] FAIL bp_head3 got=%b/%h want=1/%h", resp_valid, resp_rdata, patVal(1)); end
    @(negedge clock);
    req_valid = 1'b0; resp_ready = 1'b1;
    #1;
    totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL bp_ready_on_pop got=%b want=1", req_ready); end
    totalChecks++; if (resp_valid !== 1'b1 || resp_rdata !== patVal(1)) begin badChecks++; $display("[TB] FAIL bp_first got=%b/%h want=1/%h", resp_valid, resp_rdata, patVal(1)); end
    @(negedge clock); #1;
    totalChecks++; if (resp_valid !== 1'b1 || resp_rdata !== patVal(3)) begin badChecks++; $display("[TB] FAIL bp_second got=%b/%h want=1/%h", resp_valid, resp_rdata, patVal(3)); end
    @(negedge clock); #1;
    totalChecks++; if (resp_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL bp_drained got=%b want=0", resp_valid); end
  endtask

  // Reset with one read in flight and one queued: responses vanish, sweep
  // reruns and previously written data reads back as zero.
  task automatic test_mid_reset;
    resp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
    @(negedge clock);
    req_addr = 2'd3;
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    totalChecks++; if (resp_valid !== 1'b1) begin badChecks++; $display("[TB] FAIL mid_pre_valid got=%b want=1", resp_valid); end
    #1;
    reset_n = 1'b0;
    #1;
    totalChecks++; if (resp_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL mid_valid_drop got=%b want=0", resp_valid); end
    totalChecks++; if (init_done !== 1'b0) begin badChecks++; $display("[TB] FAIL mid_init_done got=%b want=0", init_done); end
    repeat (2) @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      totalChecks++; if (sram_en !== 1'b1 || sram_addr !== 2'(c)) begin badChecks++; $display("[TB] FAIL mid_sweep[%0d] got=%b/%0d want=1/%0d", c, sram_en, sram_addr, c); end
    end
    @(negedge clock); #1;
    totalChecks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL mid_run got=%b/%b want=1/0", req_ready, resp_valid); end
    resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      req_valid = (c < 2); req_write = 1'b0; req_addr = (c == 0) ? 2'd2 : 2'd3;
      #1;
      totalChecks++; if (resp_valid !== (c == 2 || c == 3)) begin badChecks++; $display("[TB] FAIL mid_rd_valid[%0d] got=%b want=%b", c, resp_valid, (c == 2 || c == 3)); end
      if (c == 2 || c == 3) begin
        totalChecks++; if (resp_rdata !== 66'd0) begin badChecks++; $display("[TB] FAIL mid_rd_data[%0d] got=%h want=0", c, resp_rdata); end
      end
    end
    req_valid = 1'b0;
  endtask

  // Build without the sweep: ready and init_done from the first cycle, no
  // macro activity while idle.
  task automatic test_init_zero_off;
    reset_n = 1'b0;
    @(negedge clock); #1;
    totalChecks++; if (init_done2 !== 1'b1) begin badChecks++; $display("[TB] FAIL noinit_rst_done got=%b want=1", init_done2); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      totalChecks++; if (init_done2 !== 1'b1) begin badChecks++; $display("[TB] FAIL noinit_done[%0d] got=%b want=1", c, init_done2); end
      totalChecks++; if (req_ready2 !== 1'b1) begin badChecks++; $display("[TB] FAIL noinit_ready[%0d] got=%b want=1", c, req_ready2); end
      totalChecks++; if (sram_en2 !== 1'b0) begin badChecks++; $display("[TB] FAIL noinit_en[%0d] got=%b want=0", c, sram_en2); end
      totalChecks++; if (resp_valid2 !== 1'b0) begin badChecks++; $display("[TB] FAIL noinit_valid[%0d] got=%b want=0", c, resp_valid2); end
    end
  endtask

  // Scenario sequence, then the summary line.
  initial begin
    test_reset();
    test_init_sweep();
    test_write_then_read();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_init_zero_off();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
